// File: rtl/rom_ram_copy_arbiter.sv
// rtl/rom_ram_copy_arbiter.sv - two-requester round-robin ROM-to-RAM block copy sequencer
module rom_ram_copy_arbiter #(
    parameter int ADDR_W = 4,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] src0,
    input  logic [ADDR_W-1:0] dst0,
    input  logic [LEN_W-1:0]  len0,
    output logic              done0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] dst1,
    input  logic [LEN_W-1:0]  len1,
    output logic              done1,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              write_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              busy,
    output logic              grant_id
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int EXT_W = (LEN_W > CNT_W) ? LEN_W : CNT_W;
    localparam logic [EXT_W-1:0] MAX_LEN = EXT_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_rom_addr, r_ram_addr, r_next_dst;
    logic              r_write_en;
    logic [CNT_W-1:0]  r_left;
    logic              r_gid;
    logic              r_ptr;   // winner of the most recent contested grant
    logic              r_mask;  // r_gid is barred for the IDLE cycle right after its done

    logic              w_elig0, w_elig1, w_both, w_grant, w_gid;
    logic [ADDR_W-1:0] w_src, w_dst;
    logic [EXT_W-1:0]  w_len_ext;
    logic [CNT_W-1:0]  w_len_clamp;

    assign w_elig0     = req0 && !(r_mask && !r_gid);
    assign w_elig1     = req1 && !(r_mask && r_gid);
    assign w_both      = w_elig0 && w_elig1;
    assign w_grant     = (r_state == S_IDLE) && (w_elig0 || w_elig1);
    assign w_gid       = w_both ? !r_ptr : w_elig1;
    assign w_src       = w_gid ? src1 : src0;
    assign w_dst       = w_gid ? dst1 : dst0;
    assign w_len_ext   = EXT_W'(w_gid ? len1 : len0);
    assign w_len_clamp = (w_len_ext > MAX_LEN) ? CNT_W'(MAX_LEN) : CNT_W'(w_len_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_ISSUE;
            S_ISSUE: begin
                if (r_left == '0)                w_next = S_DONE;
                else if (r_left == CNT_W'(1))    w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        done0    = (r_state == S_DONE) && !r_gid;
        done1    = (r_state == S_DONE) && r_gid;
        busy     = (r_state == S_ISSUE) || (r_state == S_DRAIN) || (w_grant && !rst);
        grant_id = (w_grant && !rst) ? w_gid : r_gid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_ram_addr <= '0;
            r_next_dst <= '0;
            r_write_en <= 1'b0;
            r_left     <= '0;
            r_gid      <= 1'b0;
            r_ptr      <= 1'b1;
            r_mask     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mask     <= 1'b0;
                    r_write_en <= 1'b0;
                    if (w_grant) begin
                        r_gid      <= w_gid;
                        r_left     <= w_len_clamp;
                        r_next_dst <= w_dst;
                        if (w_both)             r_ptr      <= w_gid;
                        if (w_len_clamp != '0)  r_rom_addr <= w_src;
                    end
                end
                S_ISSUE: begin
                    if (r_left != '0) begin
                        r_write_en <= 1'b1;
                        r_ram_addr <= r_next_dst;
                        r_next_dst <= r_next_dst + ADDR_W'(1);
                        r_left     <= r_left - CNT_W'(1);
                        if (r_left != CNT_W'(1)) r_rom_addr <= r_rom_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: r_write_en <= 1'b0;
                default: begin
                    r_write_en <= 1'b0;
                    r_mask     <= 1'b1;
                end
            endcase
        end
    end

    assign rom_addr = r_rom_addr;
    assign ram_addr = r_ram_addr;
    assign write_en = r_write_en;
endmodule

// File: tb/tb_rom_ram_copy_arbiter.sv
// tb/tb_rom_ram_copy_arbiter.sv - scoreboard bench for rom_ram_copy_arbiter
module tb_rom_ram_copy_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [3:0] src0, dst0, src1, dst1;
    logic [4:0] len0, len1;
    logic       done0, done1;
    logic [3:0] rom_addr, ram_addr;
    logic       write_en, busy, grant_id;

    int vectors = 0;
    int fails   = 0;

    logic [7:0] wq[$];   // {ram_addr, rom_addr one clk earlier} per expected write
    int         dq[$];   // expected done requester
    int         nq[$];   // expected writes in that job
    int         ptr_m;   // last contested winner; 1 after reset so requester 0 wins first

    rom_ram_copy_arbiter #(.ADDR_W(4), .LEN_W(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .src0(src0), .dst0(dst0), .len0(len0), .done0(done0),
        .req1(req1), .src1(src1), .dst1(dst1), .len1(len1), .done1(done1),
        .rom_addr(rom_addr), .write_en(write_en), .ram_addr(ram_addr),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int l);
        return (l > 16) ? 16 : l;
    endfunction

    function automatic void push_job(input int s, input int d, input int l, input int id);
        for (int k = 0; k < clamp(l); k++)
            wq.push_back({4'(d + k), 4'(s + k)});
        dq.push_back(id);
        nq.push_back(clamp(l));
    endfunction

    // Called at a negedge while the DUT is idle; returns at a negedge after the request drops.
    task automatic drive(input int id, input int s, input int d, input int l,
                         input bit solo, input bit hold);
        int cyc, nb;
        bit found;
        if (id == 0) begin req0 = 1; src0 = 4'(s); dst0 = 4'(d); len0 = 5'(l); end
        else         begin req1 = 1; src1 = 4'(s); dst1 = 4'(d); len1 = 5'(l); end
        #1;
        nb = (busy && grant_id == 1'(id)) ? 1 : 0;
        cyc = 0;
        found = 0;
        while (!found && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && grant_id == 1'(id)) nb++;
            found = (id == 0) ? done0 : done1;
            if (solo && cyc == 1) begin
                if (id == 0) begin src0 = 4'($urandom); dst0 = 4'($urandom); len0 = 5'($urandom); end
                else         begin src1 = 4'($urandom); dst1 = 4'($urandom); len1 = 5'($urandom); end
            end
        end
        chk($sformatf("done%0d_seen", id), int'(found), 1);
        if (solo && found) begin
            chk("done_latency", cyc, clamp(l) + 2);
            chk("busy_cycles", nb, clamp(l) + 2);
        end
        if (hold) begin
            @(posedge clk);
            #1;
            chk("masked_no_regrant_busy", int'(busy), 0);
        end
        @(negedge clk);
        if (id == 0) req0 = 0; else req1 = 0;
    endtask

    task automatic solo_job(input int id, input int s, input int d, input int l, input bit hold);
        push_job(s, d, l, id);
        drive(id, s, d, l, 1'b1, hold);
        repeat (2) @(negedge clk);
    endtask

    task automatic pair_job(input int s0, input int d0, input int l0,
                            input int s1, input int d1, input int l1);
        int w;
        w = 1 - ptr_m;
        ptr_m = w;
        if (w == 0) begin push_job(s0, d0, l0, 0); push_job(s1, d1, l1, 1); end
        else        begin push_job(s1, d1, l1, 1); push_job(s0, d0, l0, 0); end
        fork
            drive(0, s0, d0, l0, 1'b0, 1'b0);
            drive(1, s1, d1, l1, 1'b0, 1'b0);
        join
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every write and done the DUT presents is matched against the scoreboard.
    initial begin
        logic [3:0] prev_rom;
        logic [7:0] e;
        int wr_cnt;
        prev_rom = '0;
        wr_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wr_cnt = 0;
            end else begin
                if (write_en) begin
                    chk("write_expected", int'(wq.size() != 0), 1);
                    if (wq.size() != 0) begin
                        e = wq.pop_front();
                        chk("ram_addr", ram_addr, e[7:4]);
                        chk("rom_addr_prev_clk", prev_rom, e[3:0]);
                    end
                    wr_cnt++;
                end
                if (done0 || done1) begin
                    chk("done_onehot", int'(done0 && done1), 0);
                    chk("done_expected", int'(dq.size() != 0), 1);
                    if (dq.size() != 0) begin
                        chk("done_id", int'(done1), dq.pop_front());
                        chk("writes_per_job", wr_cnt, nq.pop_front());
                    end
                    wr_cnt = 0;
                end
            end
            prev_rom = rom_addr;
        end
    end

    initial begin
        int mode;
        rst = 1; req0 = 0; req1 = 0;
        src0 = 0; dst0 = 0; len0 = 0; src1 = 0; dst1 = 0; len1 = 0;
        ptr_m = 1;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_write_en", int'(write_en), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        rst = 0;
        repeat (2) @(negedge clk);

        solo_job(0, 2, 5, 3, 1'b0);
        solo_job(1, 14, 15, 4, 1'b0);
        solo_job(0, 7, 3, 0, 1'b0);
        solo_job(0, 1, 9, 20, 1'b1);
        pair_job(4, 8, 2, 10, 12, 3);
        pair_job(6, 0, 1, 3, 11, 5);

        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 2);
            if (mode == 2)
                pair_job($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31),
                         $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 31));
            else
                solo_job(mode, $urandom_range(0, 15), $urandom_range(0, 15),
                         $urandom_range(0, 31), 1'b0);
        end

        // Abort a len=8 job with reset at T+2, then let the held request restart it.
        push_job(3, 6, 8, 0);
        req0 = 1; src0 = 3; dst0 = 6; len0 = 8;
        repeat (3) @(posedge clk);
        #2 rst = 1;
        #1;
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_ram_addr", ram_addr, 0);
        chk("abort_write_en", int'(write_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done0", int'(done0), 0);
        wq.delete();
        dq.delete();
        nq.delete();
        ptr_m = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        push_job(3, 6, 8, 0);
        drive(0, 3, 6, 8, 1'b1, 1'b0);
        repeat (3) @(negedge clk);

        chk("writes_left_over", wq.size(), 0);
        chk("dones_left_over", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
